// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants.
// Used by the transmitter (and the receiver): FSM states, frame width, idle level.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO, power-of-2 depth, sync active-high reset.
// Ports: clk_i, reset_i, push_i/wdata_i (write), pop_i/rdata_o (head), full_o, empty_o.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 push_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic                 pop_i,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, wr_d;
  logic [AW-1:0]        rd_q, rd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 do_push, do_pop;

  // Flags decode the registered count only.
  assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];

  // Pointers wrap naturally at the power-of-2 depth.
  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter (8E1 with UART_TX_PARITY_EN).
// Ports: clk, reset (sync, high), wr_en/wr_data push, full, empty, busy,
// overflow (sticky, ovf_clr clears), serialOut (registered line, idle high).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       serialOut
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 out_q, out_d;
  logic                 ovf_q, ovf_d;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .reset_i(reset),
    .push_i (wr_en),
    .wdata_i(wr_data),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty)
  );

  assign busy      = (state_q != IDLE);
  assign overflow  = ovf_q;
  assign serialOut = out_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          // Chain straight into the next frame with no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so it changes with the state.
    unique case (state_d)
      START:   out_d = 1'b0;
      DATA:    out_d = shift_d[bit_d];
      PARITY:  out_d = ^shift_d;
      default: out_d = IDLE_LEVEL;
    endcase

    // A push against a full FIFO beats a same-cycle clear.
    if (wr_en && full) ovf_d = 1'b1;
    else if (ovf_clr)  ovf_d = 1'b0;
    else               ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      out_q   <= IDLE_LEVEL;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: self-checking bench for uart_tx_buffered.
// CLKS_PER_BIT=4, FIFO_DEPTH=4; queue-based line model plus directed cases.
module tb_uart_tx_buffered;

  localparam int CPB = 4;
  localparam int DEP = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk = 1'b0;
  logic       reset, wr_en, ovf_clr;
  logic [7:0] wr_data;
  logic       full, empty, busy, overflow, serialOut;

  int checks = 0;
  int errors = 0;

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .serialOut(serialOut)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue, queue of future line levels, frame countdown.
  logic [7:0] m_q[$];
  bit         m_line[$];
  int         m_rem = 0;
  bit         m_ovf = 0;
  bit         m_out = 1;

  bit cap_en = 0;
  bit cap[$];

  function automatic bit lvl(logic [7:0] b, int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (NB == 11 && slot == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic model_step();
    int  sz;
    bit  do_pop;
    bit  set_ovf;
    logic [7:0] b;
    if (reset) begin
      m_q.delete();
      m_line.delete();
      m_rem = 0;
      m_ovf = 0;
      m_out = 1;
      return;
    end
    sz      = m_q.size();
    do_pop  = (sz > 0) && (m_rem <= 1);
    set_ovf = wr_en && (sz == DEP);
    if (do_pop) begin
      b = m_q.pop_front();
      for (int i = 0; i < FL; i++) m_line.push_back(lvl(b, i / CPB));
      m_rem = FL;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    if (wr_en && sz < DEP) m_q.push_back(wr_data);
    if (set_ovf)      m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    m_out = (m_line.size() > 0) ? m_line.pop_front() : 1'b1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("m_out", 32'(serialOut), 32'(m_out));
    chk("m_busy", 32'(busy), 32'(m_rem > 0));
    chk("m_empty", 32'(empty), 32'(m_q.size() == 0));
    chk("m_full", 32'(full), 32'(m_q.size() == DEP));
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
    if (cap_en) cap.push_back(serialOut);
  endtask

  typedef struct {
    bit       rst;
    bit       we;
    bit [7:0] d;
    bit       clr;
    bit       eo;
    bit       eb;
    bit       ee;
    bit       ef;
    bit       ev;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [7:0] got[$];
    logic [7:0] exp5[5];
    int n;
    int j;
    logic [7:0] b;

    reset   = 1;
    wr_en   = 0;
    wr_data = 0;
    ovf_clr = 0;

    tbl[0] = '{1, 0, 8'h00, 0, 1, 0, 1, 0, 0};
    tbl[1] = '{1, 0, 8'h00, 0, 1, 0, 1, 0, 0};
    tbl[2] = '{1, 0, 8'h00, 0, 1, 0, 1, 0, 0};
    tbl[3] = '{0, 0, 8'h00, 0, 1, 0, 1, 0, 0};
    tbl[4] = '{0, 1, 8'hA5, 0, 1, 0, 0, 0, 0};

    for (int i = 0; i < 5; i++) begin
      reset   = tbl[i].rst;
      wr_en   = tbl[i].we;
      wr_data = tbl[i].d;
      ovf_clr = tbl[i].clr;
      cycle();
      chk($sformatf("t%0d_out", i), 32'(serialOut), 32'(tbl[i].eo));
      chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
      chk($sformatf("t%0d_empty", i), 32'(empty), 32'(tbl[i].ee));
      chk($sformatf("t%0d_full", i), 32'(full), 32'(tbl[i].ef));
      chk($sformatf("t%0d_ovf", i), 32'(overflow), 32'(tbl[i].ev));
    end
    wr_en = 0;

    // Single byte 0xA5: first low two cycles after the write.
    for (int i = 0; i < FL; i++) begin
      cycle();
      chk("a5_line", 32'(serialOut), 32'(lvl(8'hA5, i / CPB)));
      chk("a5_busy", 32'(busy), 32'd1);
    end
    cycle();
    chk("a5_busy_fall", 32'(busy), 32'd0);
    chk("a5_idle", 32'(serialOut), 32'd1);

    // Back-to-back 0x55, 0x0F: contiguous frames.
    wr_en   = 1;
    wr_data = 8'h55;
    cycle();
    wr_data = 8'h0F;
    cycle();
    wr_en = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      if (i > 0) cycle();
      b = (i < FL) ? 8'h55 : 8'h0F;
      chk("b2b_line", 32'(serialOut), 32'(lvl(b, (i % FL) / CPB)));
      chk("b2b_busy", 32'(busy), 32'd1);
    end
    chk("b2b_empty", 32'(empty), 32'd1);
    cycle();
    chk("b2b_done", 32'(busy), 32'd0);

    // Overflow: six writes from idle, sixth dropped.
    cap.delete();
    cap_en = 1;
    for (int k = 1; k <= 6; k++) begin
      wr_en   = 1;
      wr_data = 8'(k);
      cycle();
    end
    wr_en = 0;
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_set", 32'(overflow), 32'd1);
    ovf_clr = 1;
    cycle();
    ovf_clr = 0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    n = 0;
    while ((busy || !empty) && n < 6 * FL) begin
      cycle();
      n++;
    end
    chk("ovf_drain_timeout", 32'(busy || !empty), 32'd0);
    cap_en = 0;
    got.delete();
    j = 0;
    while (j + FL <= cap.size()) begin
      if (cap[j] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = cap[j + CPB * (k + 1) + CPB / 2];
        got.push_back(b);
        j += FL;
      end else begin
        j++;
      end
    end
    exp5 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    chk("ovf_nbytes", 32'(got.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < got.size()) chk($sformatf("ovf_byte%0d", k), 32'(got[k]), 32'(exp5[k]));
    end

    // Reset during DATA bit 3 of 0xFF, with 0x3C queued behind it.
    wr_en   = 1;
    wr_data = 8'hFF;
    cycle();
    wr_data = 8'h3C;
    cycle();
    wr_en = 0;
    for (int i = 0; i < 17; i++) cycle();
    chk("rst_bit3", 32'(serialOut), 32'd1);
    chk("rst_busy_pre", 32'(busy), 32'd1);
    chk("rst_queued", 32'(empty), 32'd0);
    reset = 1;
    cycle();
    reset = 0;
    chk("rst_out", 32'(serialOut), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 2 * FL; i++) begin
      cycle();
      chk("rst_quiet", 32'(serialOut), 32'd1);
    end

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_data = 8'($urandom);
      ovf_clr = ($urandom_range(0, 31) == 0);
      reset   = ($urandom_range(0, 499) == 0);
      cycle();
    end
    wr_en   = 0;
    ovf_clr = 0;
    reset   = 0;
    n = 0;
    while ((busy || !empty) && n < (DEP + 2) * FL) begin
      cycle();
      n++;
    end
    chk("rand_drain_timeout", 32'(busy || !empty), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
